// File: rtl/pulse_spacer_if.sv
// Event/pulse bundle between the spacer and its upstream/downstream logic.
// Master drives events and control; slave (the spacer) returns status.
interface pulse_spacer_if #(
   parameter int CNT_W = 4
);
   logic             ev_in;
   logic             busy_in;
   logic             ovf_clr;
   logic             pulse_out;
   logic [CNT_W-1:0] pending;
   logic             full;
   logic             ovf;

   modport master (
      output ev_in, busy_in, ovf_clr,
      input  pulse_out, pending, full, ovf
   );

   modport slave (
      input  ev_in, busy_in, ovf_clr,
      output pulse_out, pending, full, ovf
   );
endinterface

// File: rtl/pulse_spacer.sv
// Source-domain event spacer: queues bursty events and re-emits them
// as single-cycle pulses at least MIN_GAP cycles apart.
module pulse_spacer #(
   parameter int MIN_GAP = 6,
   parameter int CNT_W   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   pulse_spacer_if.slave  bus
);
   localparam int GW = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;
   localparam logic [GW-1:0]    GAP_LOAD = GW'(MIN_GAP - 2);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {IDLE, FIRE, GAP} state_t;

   state_t           state_q;
   logic [GW-1:0]    gap_q;
   logic             pulse_q;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic             slot, launch, full_c, acc, drop;

   // Launch decision, queue accounting and overflow detection.
   always_comb begin
      slot   = (state_q == IDLE) || ((state_q == GAP) && (gap_q == '0));
      launch = slot && ((pend_q != '0) || bus.ev_in) && !bus.busy_in;
      full_c = (pend_q == PEND_MAX);
      acc    = bus.ev_in && (!full_c || launch);
      drop   = bus.ev_in && !acc;
      pend_d = pend_q;
      if (acc && !launch) begin
         pend_d = pend_q + 1'b1;
      end else if (!acc && launch) begin
         pend_d = pend_q - 1'b1;
      end
      ovf_d = drop || (ovf_q && !bus.ovf_clr);
   end

   // Spacing FSM: one FIRE cycle, then MIN_GAP-1 GAP cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gap_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (launch) begin
                  state_q <= FIRE;
                  pulse_q <= 1'b1;
               end
            end
            FIRE: begin
               state_q <= GAP;
               gap_q   <= GAP_LOAD;
               pulse_q <= 1'b0;
            end
            GAP: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end else if (launch) begin
                  state_q <= FIRE;
                  pulse_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               pulse_q <= 1'b0;
            end
         endcase
      end
   end

   // Pending count and sticky overflow flag (a drop beats a clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.pulse_out = pulse_q;
   assign bus.pending   = pend_q;
   assign bus.full      = full_c;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pulse_spacer.sv
// Bench for pulse_spacer: timing model plus directed scenarios.
// Instance a uses a 4-bit queue, instance b a 2-bit queue.
module tb_pulse_spacer;
   localparam int MG = 6;

   logic clk;
   logic rst_n;

   pulse_spacer_if #(.CNT_W(4)) ia ();
   pulse_spacer_if #(.CNT_W(2)) ib ();

   pulse_spacer #(.MIN_GAP(MG), .CNT_W(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ia)
   );

   pulse_spacer #(.MIN_GAP(MG), .CNT_W(2)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic ev [2];
   logic busy [2];
   logic clr [2];
   assign ev[0]   = ia.ev_in;
   assign ev[1]   = ib.ev_in;
   assign busy[0] = ia.busy_in;
   assign busy[1] = ib.busy_in;
   assign clr[0]  = ia.ovf_clr;
   assign clr[1]  = ib.ovf_clr;

   int checks = 0;
   int errors = 0;

   // Model: a launch is allowed once MIN_GAP edges have passed since
   // the previous launch edge; the queue is a plain bounded integer.
   int edge_n = 0;
   int m_pend [2];
   bit m_ovf [2];
   bit m_pul [2];
   int m_last [2];
   int ev_cnt [2];
   int drop_cnt [2];
   bit m_ok, m_lau, m_dr;

   function automatic int cap(int i);
      return (i == 0) ? 15 : 3;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0;
            m_ovf[i]  = 0;
            m_pul[i]  = 0;
            m_last[i] = -1000;
         end
      end else begin
         edge_n++;
         for (int i = 0; i < 2; i++) begin
            m_ok  = (edge_n - m_last[i]) >= MG;
            m_lau = m_ok && (m_pend[i] > 0 || ev[i]) && !busy[i];
            m_dr  = ev[i] && (m_pend[i] == cap(i)) && !m_lau;
            if (ev[i]) ev_cnt[i]++;
            if (m_dr) drop_cnt[i]++;
            if (ev[i] && !m_dr) m_pend[i]++;
            if (m_lau) begin
               m_pend[i]--;
               m_last[i] = edge_n;
            end
            m_ovf[i] = m_dr ? 1'b1 : (clr[i] ? 1'b0 : m_ovf[i]);
            m_pul[i] = m_lau;
         end
      end
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   int qa [$];
   int qb [$];
   int lp [2];
   int pcnt [2];

   task automatic cmp_cycle();
      if (!rst_n) begin
         lp[0] = -1000;
         lp[1] = -1000;
         return;
      end
      chk("pulse_a", int'(ia.pulse_out), int'(m_pul[0]));
      chk("pend_a", int'(ia.pending), m_pend[0]);
      chk("full_a", int'(ia.full), int'(m_pend[0] == 15));
      chk("ovf_a", int'(ia.ovf), int'(m_ovf[0]));
      chk("pulse_b", int'(ib.pulse_out), int'(m_pul[1]));
      chk("pend_b", int'(ib.pending), m_pend[1]);
      chk("full_b", int'(ib.full), int'(m_pend[1] == 3));
      chk("ovf_b", int'(ib.ovf), int'(m_ovf[1]));
      if (ia.pulse_out) begin
         if (lp[0] > -1000) chk("space_a", int'(edge_n - lp[0] >= MG), 1);
         lp[0] = edge_n;
         qa.push_back(edge_n);
         pcnt[0]++;
      end
      if (ib.pulse_out) begin
         if (lp[1] > -1000) chk("space_b", int'(edge_n - lp[1] >= MG), 1);
         lp[1] = edge_n;
         qb.push_back(edge_n);
         pcnt[1]++;
      end
   endtask

   task automatic nc(int n);
      repeat (n) @(negedge clk);
   endtask

   int e0, st, pk;
   int pa [64];
   int po [64];
   int exp3 [6] = '{0, 1, 2, 3, 3, 3};
   int expo [6] = '{0, 0, 0, 0, 1, 1};
   int ev0 [2], dr0 [2], pc0 [2];

   initial begin
      rst_n = 1'b0;
      ia.ev_in = 0; ia.busy_in = 0; ia.ovf_clr = 0;
      ib.ev_in = 0; ib.busy_in = 0; ib.ovf_clr = 0;
      lp[0] = -1000; lp[1] = -1000;
      pcnt[0] = 0; pcnt[1] = 0;
      fork
         forever begin
            @(negedge clk);
            cmp_cycle();
         end
      join_none
      nc(3);
      chk("rst_pulse", int'(ia.pulse_out), 0);
      chk("rst_pend", int'(ia.pending), 0);
      chk("rst_full", int'(ib.full), 0);
      chk("rst_ovf", int'(ib.ovf), 0);
      rst_n = 1'b1;
      nc(3);

      // 1: single event
      e0 = edge_n + 1;
      st = qa.size();
      ia.ev_in = 1;
      nc(1);
      ia.ev_in = 0;
      chk("t1_pend", int'(ia.pending), 0);
      nc(10);
      chk("t1_cnt", qa.size() - st, 1);
      chk("t1_at", (st < qa.size()) ? qa[st] : -1, e0);

      // 2: five-cycle burst
      e0 = edge_n + 1;
      st = qa.size();
      pk = 0;
      ia.ev_in = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 4) ia.ev_in = 0;
         pa[k] = int'(ia.pending);
         if (pa[k] > pk) pk = pa[k];
      end
      chk("t2_peak", pk, 4);
      chk("t2_p23", pa[23], 1);
      chk("t2_p24", pa[24], 0);
      chk("t2_cnt", qa.size() - st, 5);
      for (int j = 0; j < 5; j++)
         chk("t2_at", (st + j < qa.size()) ? qa[st + j] : -1, e0 + 6 * j);

      // 3: overflow on the 2-bit queue
      e0 = edge_n + 1;
      st = qb.size();
      ib.ev_in = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 5) ib.ev_in = 0;
         pa[k] = int'(ib.pending);
         po[k] = int'(ib.ovf);
      end
      for (int k = 0; k < 6; k++) begin
         chk("t3_pend", pa[k], exp3[k]);
         chk("t3_ovf", po[k], expo[k]);
      end
      nc(30);
      chk("t3_cnt", qb.size() - st, 4);
      chk("t3_sticky", int'(ib.ovf), 1);
      ib.ovf_clr = 1;
      nc(1);
      ib.ovf_clr = 0;
      chk("t3_clr", int'(ib.ovf), 0);
      nc(3);

      // 4: busy hold-off
      e0 = edge_n + 1;
      st = qa.size();
      ia.busy_in = 1;
      for (int k = 0; k < 46; k++) begin
         @(negedge clk);
         if (k == 1) ia.ev_in = 1;
         if (k == 4) ia.ev_in = 0;
         if (k == 20) begin
            pa[0] = int'(ia.pending);
            ia.busy_in = 0;
         end
      end
      chk("t4_held", pa[0], 3);
      chk("t4_cnt", qa.size() - st, 3);
      for (int j = 0; j < 3; j++)
         chk("t4_at", (st + j < qa.size()) ? qa[st + j] : -1, e0 + 21 + 6 * j);

      // 5: reset during a GAP with 7 pending
      ia.ev_in = 1;
      for (int k = 0; k < 9; k++) @(negedge clk);
      ia.ev_in = 0;
      chk("t5_pend", int'(ia.pending), 7);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_pulse", int'(ia.pulse_out), 0);
      chk("t5_pendz", int'(ia.pending), 0);
      chk("t5_full", int'(ia.full), 0);
      chk("t5_ovf", int'(ia.ovf), 0);
      nc(2);
      rst_n = 1'b1;
      st = qa.size();
      nc(20);
      chk("t5_quiet", qa.size() - st, 0);

      // 6: event exactly at gap expiry with 2 pending
      e0 = edge_n + 1;
      st = qa.size();
      ia.ev_in = 1;
      for (int k = 0; k < 31; k++) begin
         @(negedge clk);
         if (k == 2) ia.ev_in = 0;
         if (k == 5) ia.ev_in = 1;
         if (k == 6) ia.ev_in = 0;
         pa[k] = int'(ia.pending);
      end
      chk("t6_p5", pa[5], 2);
      chk("t6_p6", pa[6], 2);
      chk("t6_p12", pa[12], 1);
      chk("t6_p18", pa[18], 0);
      chk("t6_cnt", qa.size() - st, 4);
      for (int j = 0; j < 4; j++)
         chk("t6_at", (st + j < qa.size()) ? qa[st + j] : -1, e0 + 6 * j);

      // random stress on both queues, then drain
      for (int i = 0; i < 2; i++) begin
         ev0[i] = ev_cnt[i];
         dr0[i] = drop_cnt[i];
         pc0[i] = pcnt[i];
      end
      for (int k = 0; k < 2000; k++) begin
         ia.ev_in   = 1'($urandom_range(0, 1));
         ia.busy_in = ($urandom_range(0, 4) == 0);
         ia.ovf_clr = ($urandom_range(0, 19) == 0);
         ib.ev_in   = 1'($urandom_range(0, 1));
         ib.busy_in = ($urandom_range(0, 4) == 0);
         ib.ovf_clr = ($urandom_range(0, 19) == 0);
         @(negedge clk);
      end
      ia.ev_in = 0; ia.busy_in = 0; ia.ovf_clr = 0;
      ib.ev_in = 0; ib.busy_in = 0; ib.ovf_clr = 0;
      nc(120);
      chk("rs_drain_a", int'(ia.pending), 0);
      chk("rs_drain_b", int'(ib.pending), 0);
      for (int i = 0; i < 2; i++)
         chk("rs_cons", pcnt[i] - pc0[i],
             (ev_cnt[i] - ev0[i]) - (drop_cnt[i] - dr0[i]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
